// File: rtl/player_hit_ctrl.sv
// Player-vs-obstacle collision controller: lives, score, hit flash and game-over sequencing.
// Drives the freeze (game) and spawn-reload (resetp) controls back into the player stage.
module player_hit_ctrl #(
    parameter int N_OBS        = 4,
    parameter int PW           = 16,
    parameter int PH           = 16,
    parameter int OW           = 32,
    parameter int OH           = 16,
    parameter int LIVES_INIT   = 3,
    parameter int FLASH_FRAMES = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 frame,
    input  logic                 btnC,
    input  logic [15:0]          px,
    input  logic [15:0]          py,
    input  logic [16*N_OBS-1:0]  obs_x,
    input  logic [16*N_OBS-1:0]  obs_y,
    output logic                 game,
    output logic                 resetp,
    output logic                 hit,
    output logic                 flash,
    output logic                 over,
    output logic [1:0]           lives,
    output logic [15:0]          score
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESPAWN,
        S_PLAY,
        S_HIT,
        S_OVER
    } state_t;

    state_t      state, state_next;
    logic [1:0]  lives_next;
    logic [15:0] score_next;
    logic [7:0]  cnt, cnt_next;
    logic        btn_q;
    logic        start;
    logic        coll;
    logic        hit_next;

    assign start = btnC & ~btn_q;

    // Bounds are widened to 17 bits so boxes near 16'hFFFF do not wrap around to 0.
    always_comb begin
        coll = 1'b0;
        for (int i = 0; i < N_OBS; i++) begin
            if (({1'b0, px} < {1'b0, obs_x[16*i +: 16]} + 17'(OW)) &&
                ({1'b0, obs_x[16*i +: 16]} < {1'b0, px} + 17'(PW)) &&
                ({1'b0, py} < {1'b0, obs_y[16*i +: 16]} + 17'(OH)) &&
                ({1'b0, obs_y[16*i +: 16]} < {1'b0, py} + 17'(PH)))
                coll = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        lives_next = lives;
        score_next = score;
        cnt_next   = cnt;
        hit_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_RESPAWN;
            end
            S_RESPAWN: begin
                state_next = S_PLAY;
            end
            S_PLAY: begin
                if (frame) begin
                    if (coll) begin
                        state_next = S_HIT;
                        hit_next   = 1'b1;
                        lives_next = lives - 2'd1;
                        cnt_next   = 8'd0;
                    end else if (score != 16'hFFFF) begin
                        score_next = score + 16'd1;
                    end
                end
            end
            S_HIT: begin
                if (frame) begin
                    cnt_next = cnt + 8'd1;
                    if (cnt == 8'(FLASH_FRAMES - 1))
                        state_next = (lives != 2'd0) ? S_RESPAWN : S_OVER;
                end
            end
            S_OVER: begin
                if (start) begin
                    state_next = S_RESPAWN;
                    lives_next = 2'(LIVES_INIT);
                    score_next = 16'd0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= S_IDLE;
            lives  <= 2'(LIVES_INIT);
            score  <= 16'd0;
            cnt    <= 8'd0;
            btn_q  <= 1'b0;
            game   <= 1'b1;
            resetp <= 1'b1;
            hit    <= 1'b0;
            flash  <= 1'b0;
            over   <= 1'b0;
        end else begin
            state  <= state_next;
            lives  <= lives_next;
            score  <= score_next;
            cnt    <= cnt_next;
            btn_q  <= btnC;
            game   <= (state_next != S_PLAY);
            resetp <= (state_next == S_RESPAWN);
            hit    <= hit_next;
            flash  <= (state_next == S_HIT) ? cnt_next[2] : 1'b0;
            over   <= (state_next == S_OVER);
        end
    end

endmodule
